// File: rtl/shift_pkg.sv
// Shared definitions for the iterative R-type shift unit: opcode/funct
// encodings, the shift-kind and FSM state enums. Rotate kind is used when SHIFT_ROT_EN is defined.
package shift_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;

  typedef enum logic [1:0] {
    SK_LL  = 2'd0,
    SK_RL  = 2'd1,
    SK_RA  = 2'd2,
    SK_ROR = 2'd3
  } shift_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational R-type shift decoder: shift detect, shift kind and amount source.
// With SHIFT_ROT_EN defined, SRL/SRLV with rot_i=1 decode as rotate-right.
module shift_decode
  import shift_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [5:0]  funct_i,
  input  logic        rot_i,
  output logic        is_shift_o,
  output shift_kind_t kind_o,
  output logic        var_amt_o
);

  always_comb begin
    is_shift_o = 1'b0;
    case (funct_i)
      F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: is_shift_o = (op_i == OP_RTYPE);
      default:                                    is_shift_o = 1'b0;
    endcase
  end

  // Bit 2 of funct distinguishes the variable-amount forms (SLLV/SRLV/SRAV).
  assign var_amt_o = funct_i[2];

`ifdef SHIFT_ROT_EN
  always_comb begin
    kind_o = SK_LL;
    case (funct_i[1:0])
      2'b10:   kind_o = rot_i ? SK_ROR : SK_RL;
      2'b11:   kind_o = SK_RA;
      default: kind_o = SK_LL;
    endcase
  end
`else
  logic unused_rot;
  assign unused_rot = rot_i;

  always_comb begin
    kind_o = SK_LL;
    case (funct_i[1:0])
      2'b10:   kind_o = SK_RL;
      2'b11:   kind_o = SK_RA;
      default: kind_o = SK_LL;
    endcase
  end
`endif

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle R-type shift unit: shifts up to STEP bits per cycle with valid/ready
// handshakes on both sides. SHIFT_ROT_EN adds rotate-right for SRL/SRLV with rot_i=1.
module shift_unit
  import shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STEP   = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [5:0]                op_i,
  input  logic [5:0]                funct_i,
  input  logic [$clog2(DATA_W)-1:0] shamt_i,
  input  logic                      rot_i,
  input  logic [DATA_W-1:0]         rs_data_i,
  input  logic [DATA_W-1:0]         rt_data_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [DATA_W-1:0]         result_o,
  output logic                      err_o,
  output logic                      busy_o
);

  localparam int SHW = $clog2(DATA_W);
  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [SHW-1:0]    rem_q, rem_d;
  shift_kind_t       kind_q, kind_d;
  logic              err_q, err_d;

  logic              dec_is_shift;
  shift_kind_t       dec_kind;
  logic              dec_var_amt;
  logic [SHW-1:0]    req_amt;
  logic [SHW-1:0]    step_n;
  logic [DATA_W-1:0] shifted;

  // Only the low SHW bits of rs carry the amount; the rest are architecturally ignored.
  logic unused_rs;
  assign unused_rs = ^rs_data_i[DATA_W-1:SHW];

  shift_decode u_decode (
    .op_i       (op_i),
    .funct_i    (funct_i),
    .rot_i      (rot_i),
    .is_shift_o (dec_is_shift),
    .kind_o     (dec_kind),
    .var_amt_o  (dec_var_amt)
  );

  assign req_amt = dec_var_amt ? rs_data_i[SHW-1:0] : shamt_i;

  // rem never exceeds DATA_W-1, so when it is larger than STEP, STEP fits in SHW bits.
  always_comb begin
    step_n = rem_q;
    if ({1'b0, rem_q} > STEP_W) begin
      step_n = STEP_W[SHW-1:0];
    end
  end

`ifdef SHIFT_ROT_EN
  localparam logic [SHW:0] DW_W = (SHW+1)'(DATA_W);
  logic [SHW:0] rot_l;
  assign rot_l = DW_W - {1'b0, step_n};
`endif

  always_comb begin
    shifted = acc_q;
    case (kind_q)
      SK_LL:   shifted = acc_q << step_n;
      SK_RL:   shifted = acc_q >> step_n;
      SK_RA:   shifted = $signed(acc_q) >>> step_n;
`ifdef SHIFT_ROT_EN
      SK_ROR:  shifted = (acc_q >> step_n) | (acc_q << rot_l);
`endif
      default: shifted = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    kind_d  = kind_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          acc_d  = rt_data_i;
          kind_d = dec_kind;
          if (!dec_is_shift) begin
            err_d   = 1'b1;
            rem_d   = '0;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            rem_d   = req_amt;
            state_d = (req_amt == '0) ? ST_DONE : ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = shifted;
        rem_d = rem_q - step_n;
        if (rem_q == step_n) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ready_i) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides any accept or handshake in the same cycle.
    if (flush_i) begin
      state_d = ST_IDLE;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      kind_q  <= SK_LL;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      kind_q  <= kind_d;
      err_q   <= err_d;
    end
  end

  assign ready_o  = (state_q == ST_IDLE);
  assign valid_o  = (state_q == ST_DONE);
  assign busy_o   = (state_q != ST_IDLE);
  assign result_o = acc_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed scoreboard bench for shift_unit with DATA_W=32, STEP=4.
// Rotate expectation follows SHIFT_ROT_EN.
module tb_shift_unit;

  localparam int DATA_W = 32;
  localparam int STEP   = 4;
  localparam int SHW    = $clog2(DATA_W);

  logic              clk;
  logic              rst_n;
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [5:0]        op_i;
  logic [5:0]        funct_i;
  logic [SHW-1:0]    shamt_i;
  logic              rot_i;
  logic [DATA_W-1:0] rs_data_i;
  logic [DATA_W-1:0] rt_data_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] result_o;
  logic              err_o;
  logic              busy_o;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic              err;
    int                lat;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  shift_unit #(.DATA_W(DATA_W), .STEP(STEP)) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .op_i      (op_i),
    .funct_i   (funct_i),
    .shamt_i   (shamt_i),
    .rot_i     (rot_i),
    .rs_data_i (rs_data_i),
    .rt_data_i (rt_data_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result_o  (result_o),
    .err_o     (err_o),
    .busy_o    (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Drive one request, then count edges (accept edge = 1) until valid_o appears.
  task automatic do_op(input string tag, input logic [5:0] op, input logic [5:0] funct,
                       input logic [SHW-1:0] shamt, input logic [DATA_W-1:0] rs,
                       input logic [DATA_W-1:0] rt, input logic rot,
                       input logic [DATA_W-1:0] exp_res, input logic exp_err, input int exp_lat);
    exp_t e;
    int   cyc;
    sb.push_back('{res: exp_res, err: exp_err, lat: exp_lat});
    op_i = op; funct_i = funct; shamt_i = shamt; rs_data_i = rs; rt_data_i = rt; rot_i = rot;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i   = 1'b0;
    rt_data_i = $urandom;
    rs_data_i = $urandom;
    shamt_i   = SHW'($urandom);
    funct_i   = 6'h20;
    cyc = 1;
    while (!valid_o && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    chk({tag, "_valid"}, 64'(valid_o), 64'(1'b1));
    chk({tag, "_lat"},   64'(cyc),     64'(e.lat));
    chk({tag, "_res"},   64'(result_o), 64'(e.res));
    chk({tag, "_err"},   64'(err_o),   64'(e.err));
    $display("op %s: result=0x%08h err=%0d latency=%0d", tag, result_o, err_o, cyc);
  endtask

  task automatic ack(input string tag);
    ready_i = 1'b1;
    #1;
    chk({tag, "_ack_rdy_lo"}, 64'(ready_o), 64'(1'b0));
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk({tag, "_ack_vld_lo"}, 64'(valid_o), 64'(1'b0));
    chk({tag, "_ack_rdy_hi"}, 64'(ready_o), 64'(1'b1));
  endtask

  initial begin
    logic [DATA_W-1:0] rot_exp;
    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    op_i = '0; funct_i = '0; shamt_i = '0; rot_i = 1'b0; rs_data_i = '0; rt_data_i = '0;

    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready",  64'(ready_o),  64'(1'b1));
    chk("rst_valid",  64'(valid_o),  64'(1'b0));
    chk("rst_busy",   64'(busy_o),   64'(1'b0));
    chk("rst_err",    64'(err_o),    64'(1'b0));
    chk("rst_result", 64'(result_o), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("sll5", 6'h00, 6'h00, 5'd5, 32'h0, 32'h00000001, 1'b0, 32'h00000020, 1'b0, 3);
    ack("sll5");
    do_op("sra31", 6'h00, 6'h03, 5'd31, 32'h0, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b0, 9);
    ack("sra31");
    do_op("srl31", 6'h00, 6'h02, 5'd31, 32'h0, 32'h80000000, 1'b0, 32'h00000001, 1'b0, 9);
    ack("srl31");
    do_op("srlv4", 6'h00, 6'h06, 5'd0, 32'hFFFFFFE4, 32'h000000F0, 1'b0, 32'h0000000F, 1'b0, 2);
    ack("srlv4");
    do_op("sll0", 6'h00, 6'h00, 5'd0, 32'h0, 32'h00001234, 1'b0, 32'h00001234, 1'b0, 1);
    ack("sll0");

    do_op("nonshift", 6'h00, 6'h20, 5'd3, 32'h0, 32'h0000DEAD, 1'b0, 32'h0000DEAD, 1'b1, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_valid",  64'(valid_o),  64'(1'b1));
      chk("hold_result", 64'(result_o), 64'(32'h0000DEAD));
      chk("hold_ready",  64'(ready_o),  64'(1'b0));
    end
    ack("nonshift");
    chk("err_cleared", 64'(err_o), 64'(1'b0));

    // Flush mid-shift: no result may appear afterwards.
    op_i = 6'h00; funct_i = 6'h00; shamt_i = 5'd31; rt_data_i = 32'h1; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    chk("flush_pre_busy", 64'(busy_o), 64'(1'b1));
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_busy",  64'(busy_o),  64'(1'b0));
    chk("flush_ready", 64'(ready_o), 64'(1'b1));
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (valid_o) seen++;
      end
      chk("flush_no_valid", 64'(seen), 64'(0));
    end
    $display("flush mid-shift: busy=%0d ready=%0d", busy_o, ready_o);

    // Asynchronous reset mid-shift, asserted between edges.
    op_i = 6'h00; funct_i = 6'h00; shamt_i = 5'd31; rt_data_i = 32'h1; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (3) begin @(posedge clk); end
    #2;
    chk("prerst_result", 64'(result_o), 64'(32'h00001000));
    rst_n = 1'b0;
    #1;
    chk("arst_ready",  64'(ready_o),  64'(1'b1));
    chk("arst_valid",  64'(valid_o),  64'(1'b0));
    chk("arst_busy",   64'(busy_o),   64'(1'b0));
    chk("arst_err",    64'(err_o),    64'(1'b0));
    chk("arst_result", 64'(result_o), 64'(0));
    $display("async reset mid-shift: result=0x%08h busy=%0d", result_o, busy_o);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("sll1", 6'h00, 6'h00, 5'd1, 32'h0, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 2);
    ack("sll1");

`ifdef SHIFT_ROT_EN
    rot_exp = 32'h80000000;
`else
    rot_exp = 32'h00000000;
`endif
    do_op("srl_rot", 6'h00, 6'h02, 5'd1, 32'h0, 32'h00000001, 1'b1, rot_exp, 1'b0, 2);
    ack("srl_rot");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
